// File: rtl/io_periph_unit.sv
// io_periph_unit: memory-mapped LED/HEX/LCD registers, debounced switches, core step enable
module io_periph_unit #(
  parameter int NUM_HEX = 8,
  parameter int SW_WIDTH = 32,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_DIV = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [31:0]            i_addr,
  input  logic [31:0]            i_wdata,
  input  logic [3:0]             i_bmask,
  input  logic                   i_wren,
  input  logic                   i_rden,
  output logic [31:0]            o_rdata,
  output logic                   o_rvalid,
  output logic [31:0]            o_io_ledr,
  output logic [31:0]            o_io_ledg,
  output logic [7*NUM_HEX-1:0]   o_io_hex,
  output logic [31:0]            o_io_lcd,
  input  logic [SW_WIDTH-1:0]    i_io_sw,
  output logic                   o_step_en
);
  localparam int HEX_WORDS = (NUM_HEX + 3) / 4;
  localparam int HW = HEX_WORDS > 1 ? $clog2(HEX_WORDS) : 1;
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SCW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [29:0] HEX_BASE = 30'h1C08;
  logic [29:0] word, hex_off;
  logic [HW-1:0] hidx;
  logic sel_ledr, sel_ledg, sel_lcd, sel_sw, sel_hex;
  logic [7:0] ledr [4];
  logic [7:0] ledg [4];
  logic [7:0] lcd [4];
  logic [6:0] dig [NUM_HEX];
  logic [31:0] hex_w [HEX_WORDS];
  logic [31:0] rd;
  logic [SW_WIDTH-1:0] s1, s2, s3, sw_db;
  logic [CW-1:0] cnt;
  logic [SCW-1:0] scnt;
  logic unused_addr;
  assign unused_addr = ^i_addr[1:0];
  assign word = i_addr[31:2];
  assign hex_off = word - HEX_BASE;
  assign hidx = hex_off[HW-1:0];
  assign sel_ledr = word == 30'h1C00;
  assign sel_ledg = word == 30'h1C04;
  assign sel_lcd = word == 30'h1C0C;
  assign sel_sw = word == 30'h1E00;
  assign sel_hex = word >= HEX_BASE && hex_off < 30'(HEX_WORDS);
  for (genvar b = 0; b < 4; b++) begin : g_lane
    always_ff @(posedge i_clk or negedge i_reset)
      if (!i_reset) begin
        ledr[b] <= '0;
        ledg[b] <= '0;
        lcd[b] <= '0;
      end else if (i_wren && i_bmask[b]) begin
        if (sel_ledr) ledr[b] <= i_wdata[8*b +: 8];
        if (sel_ledg) ledg[b] <= i_wdata[8*b +: 8];
        if (sel_lcd) lcd[b] <= i_wdata[8*b +: 8];
      end
  end
  assign o_io_ledr = {ledr[3], ledr[2], ledr[1], ledr[0]};
  assign o_io_ledg = {ledg[3], ledg[2], ledg[1], ledg[0]};
  assign o_io_lcd = {lcd[3], lcd[2], lcd[1], lcd[0]};
  // Digits reset to all-ones so the active-low display starts blank
  for (genvar k = 0; k < NUM_HEX; k++) begin : g_dig
    always_ff @(posedge i_clk or negedge i_reset)
      if (!i_reset) dig[k] <= 7'h7F;
      else if (i_wren && sel_hex && hex_off == 30'(k / 4) && i_bmask[k % 4])
        dig[k] <= i_wdata[8*(k % 4) +: 7];
    assign o_io_hex[7*k +: 7] = dig[k];
  end
  for (genvar j = 0; j < HEX_WORDS; j++) begin : g_word
    for (genvar b = 0; b < 4; b++) begin : g_byte
      if (4*j + b < NUM_HEX) begin : g_on
        assign hex_w[j][8*b +: 8] = {1'b0, dig[4*j + b]};
      end else begin : g_off
        assign hex_w[j][8*b +: 8] = 8'h00;
      end
    end
  end
  always_comb
    rd = sel_ledr ? o_io_ledr :
         sel_ledg ? o_io_ledg :
         sel_lcd  ? o_io_lcd :
         sel_hex  ? hex_w[hidx] :
         sel_sw   ? 32'(sw_db) : 32'h0;
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      o_rdata <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= i_rden;
      if (i_rden) o_rdata <= rd;
    end
  // One counter shared by all switch bits: any change restarts the stability window
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      sw_db <= '0;
      cnt <= '0;
    end else begin
      s1 <= i_io_sw;
      s2 <= s1;
      if (s2 != s3) begin
        s3 <= s2;
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) sw_db <= s3;
      else cnt <= cnt + 1'b1;
    end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      scnt <= '0;
      o_step_en <= 1'b0;
    end else begin
      o_step_en <= scnt == SCW'(STEP_DIV - 1);
      scnt <= scnt == SCW'(STEP_DIV - 1) ? '0 : scnt + 1'b1;
    end
endmodule

// File: tb/tb_io_periph_unit.sv
// tb_io_periph_unit: vector table, switch/step/reset sequences and randomized model comparison
module tb_io_periph_unit;
  localparam int NH = 6, SWW = 8, DB = 16, SD = 3;
  logic clk = 0, rst_n = 0;
  logic [31:0] addr = 0, wdata = 0, rdata, ledr, ledg, lcd;
  logic [3:0] bmask = 0;
  logic wren = 0, rden = 0, rvalid, step;
  logic [7*NH-1:0] hex;
  logic [SWW-1:0] sw = 0;
  int passed = 0, total = 0;
  logic [31:0] last = 0;
  logic [31:0] m_ledr, m_ledg, m_lcd;
  logic [6:0] m_hex [NH];
  logic [SWW-1:0] m_sw;

  io_periph_unit #(.NUM_HEX(NH), .SW_WIDTH(SWW), .DEBOUNCE_CYCLES(DB), .STEP_DIV(SD)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_addr(addr), .i_wdata(wdata), .i_bmask(bmask),
    .i_wren(wren), .i_rden(rden), .o_rdata(rdata), .o_rvalid(rvalid), .o_io_ledr(ledr),
    .o_io_ledg(ledg), .o_io_hex(hex), .o_io_lcd(lcd), .i_io_sw(sw), .o_step_en(step));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus(input logic [31:0] a, d, input logic [3:0] m, input logic w, r);
    addr = a; wdata = d; bmask = m; wren = w; rden = r;
  endtask

  task automatic m_reset();
    m_ledr = 0; m_ledg = 0; m_lcd = 0; m_sw = 0;
    for (int k = 0; k < NH; k++) m_hex[k] = 7'h7F;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w, r;
    int j;
    w = a & ~32'h3;
    r = 0;
    if (w == 32'h7000) r = m_ledr;
    else if (w == 32'h7010) r = m_ledg;
    else if (w == 32'h7030) r = m_lcd;
    else if (w == 32'h7800) r = 32'(m_sw);
    else if (w >= 32'h7020 && w < 32'h7020 + 4 * ((NH + 3) / 4)) begin
      j = int'((w - 32'h7020) / 4);
      for (int b = 0; b < 4; b++)
        if (4 * j + b < NH) r = r | (32'(m_hex[4 * j + b]) << (8 * b));
    end
    return r;
  endfunction

  task automatic m_write(input logic [31:0] a, d, input logic [3:0] m);
    logic [31:0] w, mask;
    int j;
    w = a & ~32'h3;
    mask = 0;
    for (int b = 0; b < 4; b++) if (((m >> b) & 4'h1) != 0) mask = mask | (32'hFF << (8 * b));
    if (w == 32'h7000) m_ledr = (m_ledr & ~mask) | (d & mask);
    else if (w == 32'h7010) m_ledg = (m_ledg & ~mask) | (d & mask);
    else if (w == 32'h7030) m_lcd = (m_lcd & ~mask) | (d & mask);
    else if (w >= 32'h7020 && w < 32'h7020 + 4 * ((NH + 3) / 4)) begin
      j = int'((w - 32'h7020) / 4);
      for (int b = 0; b < 4; b++)
        if (4 * j + b < NH && ((m >> b) & 4'h1) != 0) m_hex[4 * j + b] = 7'(d >> (8 * b));
    end
  endtask

  function automatic logic [7*NH-1:0] m_hexv();
    logic [7*NH-1:0] v = 0;
    for (int k = 0; k < NH; k++) v = v | ((7*NH)'(m_hex[k]) << (7 * k));
    return v;
  endfunction

  typedef struct {
    logic [31:0] a, d;
    logic [3:0] m;
    logic w, r;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [16];
  logic [31:0] alist [9];

  initial begin
    vt[0]  = '{32'h7800, 32'h0,        4'h0, 1'b0, 1'b1, 32'h0};
    vt[1]  = '{32'h7000, 32'hDEADBEEF, 4'h5, 1'b1, 1'b0, 32'h0};
    vt[2]  = '{32'h7000, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00AD00EF};
    vt[3]  = '{32'h7024, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 32'h0};
    vt[4]  = '{32'h7024, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00007F7F};
    vt[5]  = '{32'h7020, 32'h00000081, 4'h1, 1'b1, 1'b0, 32'h0};
    vt[6]  = '{32'h7020, 32'h0,        4'h0, 1'b0, 1'b1, 32'h7F7F7F01};
    vt[7]  = '{32'h7030, 32'h12345678, 4'hF, 1'b1, 1'b1, 32'h0};
    vt[8]  = '{32'h7030, 32'h0,        4'h0, 1'b0, 1'b1, 32'h12345678};
    vt[9]  = '{32'h7800, 32'hFF,       4'hF, 1'b1, 1'b1, 32'h0};
    vt[10] = '{32'h7800, 32'h0,        4'h0, 1'b0, 1'b1, 32'h0};
    vt[11] = '{32'h7040, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'h0};
    vt[12] = '{32'h7028, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'h0};
    vt[13] = '{32'h7010, 32'h11223344, 4'h8, 1'b1, 1'b0, 32'h0};
    vt[14] = '{32'h7013, 32'h0,        4'h0, 1'b0, 1'b1, 32'h11000000};
    vt[15] = '{32'h7000, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00AD00EF};
    alist = '{32'h7000, 32'h7010, 32'h7020, 32'h7024, 32'h7028, 32'h7030, 32'h7800, 32'h7004, 32'h702C};
    // reset state
    cyc(); cyc();
    chk("rst_ledr", ledr, 0);
    chk("rst_ledg", ledg, 0);
    chk("rst_lcd", lcd, 0);
    chk("rst_hex", hex, {NH{7'h7F}});
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_step", step, 0);
    rst_n = 1;
    // vector table
    for (int i = 0; i < 16; i++) begin
      bus(vt[i].a, vt[i].d, vt[i].m, vt[i].w, vt[i].r);
      cyc();
      chk($sformatf("vec%0d_rvalid", i), rvalid, vt[i].r);
      if (vt[i].r) last = vt[i].exp;
      chk($sformatf("vec%0d_rdata", i), rdata, last);
    end
    bus(0, 0, 0, 0, 0);
    cyc();
    chk("rvalid_drop", rvalid, 0);
    chk("rdata_hold", rdata, 32'h00AD00EF);
    chk("out_ledr", ledr, 32'h00AD00EF);
    chk("out_ledg", ledg, 32'h11000000);
    chk("out_lcd", lcd, 32'h12345678);
    chk("out_hex", hex, {{5{7'h7F}}, 7'h01});
    // debounce: change sampled at e0 lands in sw_db after e0+18, visible on a read one edge later
    sw = 8'h05;
    bus(32'h7800, 0, 0, 0, 1);
    for (int k = 0; k < 22; k++) begin
      cyc();
      chk($sformatf("sw_lat%0d", k), rdata, k >= DB + 3 ? 32'h5 : 32'h0);
    end
    sw = 8'h01;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("sw_glitch", rdata, 32'h5);
    end
    sw = 8'h05;
    for (int k = 0; k < 30; k++) begin
      cyc();
      chk("sw_after_glitch", rdata, 32'h5);
    end
    // step enable from clean release, then async reset while step and rvalid are high
    sw = 0;
    bus(0, 0, 0, 0, 0);
    rst_n = 0;
    cyc();
    rst_n = 1;
    for (int e = 1; e <= 5; e++) begin
      cyc();
      chk($sformatf("step_e%0d", e), step, (e % SD) == 0);
    end
    bus(32'h7030, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    chk("step_e6", step, 1);
    chk("rvalid_pre_rst", rvalid, 1);
    #1 rst_n = 0;
    #1;
    chk("step_async_rst", step, 0);
    chk("rvalid_async_rst", rvalid, 0);
    chk("rdata_async_rst", rdata, 0);
    chk("lcd_async_rst", lcd, 0);
    chk("hex_async_rst", hex, {NH{7'h7F}});
    @(negedge clk);
    bus(0, 0, 0, 0, 0);
    cyc();
    rst_n = 1;
    m_reset();
    for (int e = 1; e <= 7; e++) begin
      cyc();
      chk($sformatf("step_rel_e%0d", e), step, (e % SD) == 0);
    end
    // randomized traffic against the reference model
    for (int n = 8; n < 408; n++) begin
      logic [31:0] a, d, exp;
      logic [3:0] m;
      logic w, r;
      a = alist[$urandom_range(0, 8)] | 32'($urandom_range(0, 3));
      d = $urandom;
      m = 4'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      exp = m_read(a);
      if (w) m_write(a, d, m);
      bus(a, d, m, w, r);
      cyc();
      if (r) last = exp;
      chk("rnd_rvalid", rvalid, r);
      chk("rnd_rdata", rdata, last);
      chk("rnd_ledr", ledr, m_ledr);
      chk("rnd_ledg", ledg, m_ledg);
      chk("rnd_lcd", lcd, m_lcd);
      chk("rnd_hex", hex, m_hexv());
      chk("rnd_step", step, (n % SD) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
